video_pattern_gen: RTL and testbench

Video timing and test-pattern source that drives the pixel-side interface consumed by the luma converter: 24-bit RGB with data-valid, hsync and vsync. It generates raster timing from parameterised porch/sync widths and fills the active area with a selectable test pattern. It is used as the stimulus source for the grayscale pipeline on hardware and in system simulation.

---
 rtl/video_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Raster timing generator with a selectable test pattern in the active area.
// Counters and the latched pattern settings advance in RUN; every output is
// a registered function of the counter state, so it lags the counters by one clock.
//
// state | meaning
// IDLE  | counters parked at 0, all outputs 0, waiting for en_i
// RUN   | raster running; en_i is only honoured at the end of a frame
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [23:0] solid_i,
  output logic [23:0] rgb_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        line_end_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are kept at least 8/6 bits wide so the ramp and checker bits exist
  // even for tiny rasters.
  localparam int HW  = ($clog2(H_TOTAL + 1) > 8) ? $clog2(H_TOTAL + 1) : 8;
  localparam int VW  = ($clog2(V_TOTAL + 1) > 6) ? $clog2(V_TOTAL + 1) : 6;
  localparam int BW  = H_ACTIVE / 8;
  localparam int BCW = ($clog2(BW) > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_ACT_END = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]  H_SYNC_S  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SYNC_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SYNC_S  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SYNC_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BCW-1:0] BAR_LAST  = BCW'(BW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [BCW-1:0] bar_px_q, bar_px_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          dv_q, dv_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          line_end_q, line_end_d;
  logic          frame_start_q, frame_start_d;

  logic          end_line;
  logic          end_frame;
  logic [23:0]   pattern;

  assign end_line  = (h_cnt_q == H_LAST);
  assign end_frame = end_line && (v_cnt_q == V_LAST);

  // Next-state: raster counters, bar index tracker, settings latch at frame boundaries.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    mode_d    = mode_q;
    solid_d   = solid_q;
    case (state_q)
      IDLE: begin
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        bar_idx_d = '0;
        bar_px_d  = '0;
        if (en_i) begin
          state_d = RUN;
          mode_d  = mode_i;
          solid_d = solid_i;
        end
      end
      RUN: begin
        if (end_line) begin
          h_cnt_d   = '0;
          bar_idx_d = '0;
          bar_px_d  = '0;
          if (end_frame) begin
            v_cnt_d = '0;
            if (en_i) begin
              mode_d  = mode_i;
              solid_d = solid_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
          // Bar index steps every BW pixels without dividing h_cnt.
          if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_px_d = bar_px_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: region flags and pattern from the current counter state.
  always_comb begin
    pattern = 24'h000000;
    case (mode_q)
      2'd0: begin
        case (bar_idx_q)
          3'd0:    pattern = 24'hFFFFFF;
          3'd1:    pattern = 24'hFFFF00;
          3'd2:    pattern = 24'h00FFFF;
          3'd3:    pattern = 24'h00FF00;
          3'd4:    pattern = 24'hFF00FF;
          3'd5:    pattern = 24'hFF0000;
          3'd6:    pattern = 24'h0000FF;
          default: pattern = 24'h000000;
        endcase
      end
      2'd1:    pattern = {3{h_cnt_q[7:0]}};
      2'd2:    pattern = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
      default: pattern = solid_q;
    endcase
    dv_d          = (state_q == RUN) && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d          = (state_q == RUN) && (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
    vs_d          = (state_q == RUN) && (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
    rgb_d         = dv_d ? pattern : 24'h000000;
    line_end_d    = dv_d && (h_cnt_q == H_ACT_END);
    frame_start_d = dv_d && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // State, counter and settings registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_idx_q <= '0;
      bar_px_q  <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
    end
  end

  // Registered pixel-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q         <= '0;
      dv_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      dv_q          <= dv_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign dv_o          = dv_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign line_end_o    = line_end_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a small raster model feeds a scoreboard queue on
// the small-raster instance; a full-size instance checks ramp and checker pixels.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [23:0] rgb;
    logic dv, hs, vs, le, fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en_i;
  logic [1:0]  mode_i;
  logic [23:0] solid_i;
  logic [23:0] rgb_o;
  logic        dv_o, hs_o, vs_o, line_end_o, frame_start_o;

  logic        rst2, en2;
  logic [1:0]  mode2;
  logic [23:0] solid2;
  logic [23:0] rgb2;
  logic        dv2, hs2, vs2, le2, fs2;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .solid_i(solid_i),
    .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .line_end_o(line_end_o), .frame_start_o(frame_start_o)
  );

  video_pattern_gen dut_full (
    .clk(clk), .rst(rst2), .en_i(en2), .mode_i(mode2), .solid_i(solid2),
    .rgb_o(rgb2), .dv_o(dv2), .hs_o(hs2), .vs_o(vs2),
    .line_end_o(le2), .frame_start_o(fs2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference raster model
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int          m_run = 0, m_h = 0, m_v = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_solid = 24'h0;
  exp_t        sb[$];

  // Monitors
  int cyc = 0, dv_run = 0, hs_run = 0, vs_run = 0, frame_dv = 0, last_fs = -1;

  function automatic exp_t model_out();
    exp_t e;
    logic [7:0] hb;
    e = '0;
    if (m_run != 0) begin
      e.dv = (m_h < HA) && (m_v < VA);
      e.hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
      e.vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
      e.le = e.dv && (m_h == HA - 1);
      e.fs = e.dv && (m_h == 0) && (m_v == 0);
      hb = m_h[7:0];
      if (e.dv) begin
        case (m_mode)
          2'd0: e.rgb = bars[m_h / (HA / 8)];
          2'd1: e.rgb = {hb, hb, hb};
          2'd2: e.rgb = ((((m_h / 32) % 2) ^ ((m_v / 32) % 2)) != 0) ? 24'h000000 : 24'hFFFFFF;
          default: e.rgb = m_solid;
        endcase
      end
    end
    return e;
  endfunction

  task automatic model_step();
    if (m_run == 0) begin
      if (en_i) begin
        m_run = 1; m_h = 0; m_v = 0; m_mode = mode_i; m_solid = solid_i;
      end
    end else if (m_h == HT - 1 && m_v == VT - 1) begin
      m_h = 0; m_v = 0;
      if (en_i) begin
        m_mode = mode_i; m_solid = solid_i;
      end else begin
        m_run = 0;
      end
    end else if (m_h == HT - 1) begin
      m_h = 0; m_v++;
    end else begin
      m_h++;
    end
  endtask

  task automatic reset_monitors();
    dv_run = 0; hs_run = 0; vs_run = 0; frame_dv = 0; last_fs = -1;
  endtask

  // One clock on the small instance: predict, push, clock, pop and compare.
  task automatic tick();
    exp_t e, p;
    e = model_out();
    model_step();
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    p = sb.pop_front();
    check("rgb", {8'h0, rgb_o}, {8'h0, p.rgb});
    check("dv", {31'h0, dv_o}, {31'h0, p.dv});
    check("hs", {31'h0, hs_o}, {31'h0, p.hs});
    check("vs", {31'h0, vs_o}, {31'h0, p.vs});
    check("line_end", {31'h0, line_end_o}, {31'h0, p.le});
    check("frame_start", {31'h0, frame_start_o}, {31'h0, p.fs});
    if (frame_start_o) begin
      if (last_fs >= 0) begin
        check("frame_period", cyc - last_fs, HT * VT);
        check("frame_dv_count", frame_dv, HA * VA);
      end
      last_fs  = cyc;
      frame_dv = 0;
    end
    if (dv_o) begin
      dv_run++; frame_dv++;
    end else if (dv_run > 0) begin
      check("dv_run_len", dv_run, HA); dv_run = 0;
    end
    if (hs_o) hs_run++;
    else if (hs_run > 0) begin
      check("hs_run_len", hs_run, HS); hs_run = 0;
    end
    if (vs_o) vs_run++;
    else if (vs_run > 0) begin
      check("vs_run_len", vs_run, HT * VS); vs_run = 0;
    end
  endtask

  // Ticks until frame_start_o is seen; returns the number of ticks taken.
  task automatic ticks_to_fs(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (frame_start_o) break;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs2();
    for (int i = 0; i < 2000; i++) begin
      if (fs2) break;
      @(posedge clk);
      #1;
    end
    check("full_fs_seen", {31'h0, fs2}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, found;
    rst = 1'b1; en_i = 1'b1; mode_i = 2'd0; solid_i = 24'h0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 2'd0; solid2 = 24'h0;

    // Reset state
    wait_clks(3);
    check("rst_rgb", {8'h0, rgb_o}, 32'h0);
    check("rst_ctrl", {27'h0, dv_o, hs_o, vs_o, line_end_o, frame_start_o}, 32'h0);
    #4 rst = 1'b0;

    // Start-up latency and frame of colour bars
    ticks_to_fs(n);
    check("first_dv_latency", n, 2);
    check("fs_with_dv", {31'h0, dv_o}, 32'h1);

    // Mode change mid line 2 must wait for the frame wrap
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_run != 0 && m_v == 2 && m_h == 8) begin found = 1; break; end
      tick();
    end
    check("reach_line2", found, 1);
    mode_i = 2'd3; solid_i = 24'h123456;
    ticks_to_fs(n);
    check("fs_frame2", {31'h0, frame_start_o}, 32'h1);
    check("frame2_px0", {8'h0, rgb_o}, 32'h123456);
    cnt = 0;
    for (int i = 0; i < HT * VT - 1; i++) begin
      tick();
      if (dv_o && rgb_o == 24'h123456) cnt++;
    end
    check("frame2_solid_px", cnt, HA * VA - 1);

    // Graceful stop mid-frame
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_run != 0 && m_v == 1) begin found = 1; break; end
      tick();
    end
    check("reach_stop_point", found, 1);
    en_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_run == 0) break;
      tick();
    end
    check("stop_frame_dv", frame_dv, HA * VA);
    reset_monitors();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rgb_o != 0 || dv_o || hs_o || vs_o || line_end_o || frame_start_o) cnt++;
    end
    check("idle_quiet", cnt, 0);
    en_i = 1'b1;
    ticks_to_fs(n);
    check("restart_latency", n, 2);
    check("restart_px0", {8'h0, rgb_o}, 32'h123456);

    // Asynchronous reset mid active line
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_run != 0 && m_v == 1 && m_h == 5) begin found = 1; break; end
      tick();
    end
    check("reach_rst_point", found, 1);
    check("pre_rst_dv", {31'h0, dv_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rgb", {8'h0, rgb_o}, 32'h0);
    check("async_rst_ctrl", {27'h0, dv_o, hs_o, vs_o, line_end_o, frame_start_o}, 32'h0);
    m_run = 0; m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 24'h0;
    reset_monitors();
    mode_i = 2'd0;
    wait_clks(2);
    rst = 1'b0;
    ticks_to_fs(n);
    check("post_rst_latency", n, 2);
    check("post_rst_px0", {8'h0, rgb_o}, 32'hFFFFFF);
    for (int i = 0; i < 2 * HT * VT; i++) tick();

    // Full-size raster: gray ramp
    en_i = 1'b0;
    mode2 = 2'd1; solid2 = 24'hABCDEF;
    #2 rst2 = 1'b0;
    en2 = 1'b1;
    wait_clks(1);
    wait_fs2();
    wait_clks(300);
    check("ramp_px300_dv", {31'h0, dv2}, 32'h1);
    check("ramp_px300_l0", {8'h0, rgb2}, 32'h2C2C2C);
    wait_clks(800);
    check("ramp_px300_l1", {8'h0, rgb2}, 32'h2C2C2C);

    // Full-size raster: checkerboard
    #2 rst2 = 1'b1;
    #1;
    check("full_async_rst", {8'h0, rgb2}, 32'h0);
    mode2 = 2'd2;
    #1 rst2 = 1'b0;
    wait_clks(1);
    wait_fs2();
    wait_clks(31);
    check("checker_31_0", {8'h0, rgb2}, 32'hFFFFFF);
    wait_clks(1);
    check("checker_32_0_dv", {31'h0, dv2}, 32'h1);
    check("checker_32_0", {8'h0, rgb2}, 32'h000000);
    wait_clks(32 * 800);
    check("checker_32_32_dv", {31'h0, dv2}, 32'h1);
    check("checker_32_32", {8'h0, rgb2}, 32'hFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
